// File: rtl/fighter_ctrl.sv
// Per-player fighter controller: movement, timed attack phases, block/hitstun
// handling, health and sticky KO, all paced by the frame enable tick.
module fighter_ctrl #(
   parameter int SIDE         = 0,
   parameter int START_X      = 210,
   parameter int X_MIN        = 50,
   parameter int X_MAX        = 490,
   parameter int SPEED        = 15,
   parameter int KNOCKBACK    = 4,
   parameter int ATK_STARTUP  = 4,
   parameter int ATK_ACTIVE   = 2,
   parameter int ATK_RECOVERY = 16,
   parameter int HITSTUN      = 12,
   parameter int BLOCKSTUN    = 6,
   parameter int HP_INIT      = 100,
   parameter int DAMAGE       = 10,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       left,
   input  logic       right,
   input  logic       attack,
   input  logic       hit_in,
   output logic [9:0] posx,
   output logic [9:0] posy,
   output logic [3:0] state,
   output logic       hitbox_active,
   output logic [7:0] health,
   output logic       ko
);

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_FWD         = 4'd1,
      S_BACK        = 4'd2,
      S_ATK_START   = 4'd3,
      S_ATK_ACTIVE  = 4'd4,
      S_ATK_RECOVER = 4'd5,
      S_BLOCKSTUN   = 4'd6,
      S_HITSTUN     = 4'd7,
      S_KO          = 4'd8
   } state_t;

   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(ATK_STARTUP - 1);
   localparam logic [CNT_W-1:0] ACTIVE_LAST  = CNT_W'(ATK_ACTIVE - 1);
   localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(ATK_RECOVERY - 1);
   localparam logic [CNT_W-1:0] HIT_LAST     = CNT_W'(HITSTUN - 1);
   localparam logic [CNT_W-1:0] BLOCK_LAST   = CNT_W'(BLOCKSTUN - 1);

   localparam logic signed [10:0] FWD_STEP  = (SIDE == 0) ? 11'(SPEED) : -11'(SPEED);
   localparam logic signed [10:0] KB_STEP   = (SIDE == 0) ? -11'(KNOCKBACK) : 11'(KNOCKBACK);
   localparam logic signed [10:0] X_MIN_S   = 11'(X_MIN);
   localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
   localparam logic [7:0]         DAMAGE_8  = 8'(DAMAGE);

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [9:0]       posx_q, posx_n;
   logic [7:0]       health_q, health_n;
   logic [7:0]       dmg_hp;
   logic             back_req, fwd_req;
   logic signed [10:0] step, px_sum;

   // Both directions held counts as backing off (i.e. blocking).
   assign back_req = (left & right) | ((SIDE == 0) ? left : right);
   assign fwd_req  = ~back_req & ((SIDE == 0) ? right : left);
   assign dmg_hp   = (health_q > DAMAGE_8) ? health_q - DAMAGE_8 : 8'd0;

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      health_n = health_q;
      case (state_q)
         S_IDLE, S_FWD, S_BACK: begin
            cnt_n = '0;
            if (hit_in) begin
               if (state_q == S_BACK) begin
                  state_n = S_BLOCKSTUN;
               end else begin
                  health_n = dmg_hp;
                  state_n  = (dmg_hp == 8'd0) ? S_KO : S_HITSTUN;
               end
            end else if (attack) begin
               state_n = S_ATK_START;
            end else if (back_req) begin
               state_n = S_BACK;
            end else if (fwd_req) begin
               state_n = S_FWD;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_ATK_START, S_ATK_ACTIVE, S_ATK_RECOVER, S_HITSTUN: begin
            if (hit_in) begin
               health_n = dmg_hp;
               state_n  = (dmg_hp == 8'd0) ? S_KO : S_HITSTUN;
               cnt_n    = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
               if (state_q == S_ATK_START && cnt_q == START_LAST) begin
                  state_n = S_ATK_ACTIVE;
                  cnt_n   = '0;
               end else if (state_q == S_ATK_ACTIVE && cnt_q == ACTIVE_LAST) begin
                  state_n = S_ATK_RECOVER;
                  cnt_n   = '0;
               end else if (state_q == S_ATK_RECOVER && cnt_q == RECOVER_LAST) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end else if (state_q == S_HITSTUN && cnt_q == HIT_LAST) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end
            end
         end
         S_BLOCKSTUN: begin
            if (hit_in) begin
               cnt_n = '0;
            end else if (cnt_q == BLOCK_LAST) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         S_KO: begin
            state_n = S_KO;
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Motion follows the state already registered, giving one tick of lag.
   always_comb begin
      step = '0;
      case (state_q)
         S_FWD:     step = FWD_STEP;
         S_BACK:    step = -FWD_STEP;
         S_HITSTUN: step = KB_STEP;
         default:   step = '0;
      endcase
      px_sum = $signed({1'b0, posx_q}) + step;
      if (px_sum < X_MIN_S)      posx_n = 10'(X_MIN);
      else if (px_sum > X_MAX_S) posx_n = 10'(X_MAX);
      else                       posx_n = px_sum[9:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         posx_q        <= 10'(START_X);
         health_q      <= 8'(HP_INIT);
         hitbox_active <= 1'b0;
         ko            <= 1'b0;
      end else if (tick) begin
         state_q       <= state_n;
         cnt_q         <= cnt_n;
         posx_q        <= posx_n;
         health_q      <= health_n;
         hitbox_active <= (state_n == S_ATK_ACTIVE);
         ko            <= (state_n == S_KO);
      end
   end

   assign state  = state_q;
   assign posx   = posx_q;
   assign posy   = 10'd170;
   assign health = health_q;

endmodule
